// File: rtl/note_pkg.sv
// note_pkg: shared note word width, rest code and half-period constants (C4..B5 at 50 MHz).
package note_pkg;
   localparam int NOTE_W = 19;
   localparam logic [NOTE_W-1:0] REST = '0;
   localparam logic [NOTE_W-1:0] C4 = 19'd95556;
   localparam logic [NOTE_W-1:0] D4 = 19'd85131;
   localparam logic [NOTE_W-1:0] E4 = 19'd75843;
   localparam logic [NOTE_W-1:0] F4 = 19'd71586;
   localparam logic [NOTE_W-1:0] G4 = 19'd63776;
   localparam logic [NOTE_W-1:0] A4 = 19'd56818;
   localparam logic [NOTE_W-1:0] B4 = 19'd50619;
   localparam logic [NOTE_W-1:0] C5 = 19'd47778;
   localparam logic [NOTE_W-1:0] D5 = 19'd42566;
   localparam logic [NOTE_W-1:0] E5 = 19'd37921;
   localparam logic [NOTE_W-1:0] F5 = 19'd35793;
   localparam logic [NOTE_W-1:0] G5 = 19'd31888;
   localparam logic [NOTE_W-1:0] A5 = 19'd28409;
   localparam logic [NOTE_W-1:0] B5 = 19'd25310;
endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that saturates at zero, with a zero flag.
module hold_timer #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk_i) cnt_q <= !rst_ni ? '0 : cnt_d;
   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/note_arbiter.sv
// note_arbiter: fixed-priority voice arbiter with minimum hold time and a silent gap between owners.
module note_arbiter #(
   parameter int NOTE_W   = note_pkg::NOTE_W,
   parameter int MIN_HOLD = 1_500_000,
   parameter int GAP_CYC  = 50_000
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic [2:0]        req,
   input  logic [NOTE_W-1:0] period0,
   input  logic [NOTE_W-1:0] period1,
   input  logic [NOTE_W-1:0] period2,
   output logic [NOTE_W-1:0] out_note,
   output logic [2:0]        grant,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, HOLD, OWN, GAP} state_e;
   localparam int HW = MIN_HOLD > 1 ? $clog2(MIN_HOLD) : 1;
   localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
   state_e state_q, state_d;
   logic [2:0] grant_q, grant_d, win;
   logic [NOTE_W-1:0] note_q, note_d, win_p, own_p;
   logic busy_q, busy_d, own_req, hi_req, hold_zero, gap_zero, arb, keep;
   assign win     = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
   assign win_p   = win[0] ? period0 : win[1] ? period1 : period2;
   assign own_p   = grant_q[0] ? period0 : grant_q[1] ? period1 : period2;
   assign own_req = |(req & grant_q);
   // grant_q - 1 masks every source of higher priority than the one-hot owner
   assign hi_req  = |(req & (grant_q - 3'd1));
   hold_timer #(.W(HW)) u_hold (
      .clk_i(CLOCK_50), .rst_ni(resetn), .load_i(arb), .load_val_i(HW'(MIN_HOLD - 1)),
      .dec_i(state_q == HOLD), .zero_o(hold_zero)
   );
   hold_timer #(.W(GW)) u_gap (
      .clk_i(CLOCK_50), .rst_ni(resetn), .load_i(state_d == GAP && state_q != GAP),
      .load_val_i(GW'(GAP_CYC - 1)), .dec_i(state_q == GAP), .zero_o(gap_zero)
   );
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q <= IDLE;
         grant_q <= '0;
         note_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         note_q  <= note_d;
         busy_q  <= busy_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = |req ? HOLD : IDLE;
         HOLD: state_d = !own_req ? GAP : hold_zero ? OWN : HOLD;
         OWN:  state_d = (!own_req || hi_req) ? GAP : OWN;
         GAP:  state_d = !gap_zero ? GAP : |req ? HOLD : IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      arb     = (state_q == IDLE || state_q == GAP) && state_d == HOLD;
      keep    = state_d == HOLD || state_d == OWN;
      grant_d = arb ? win : keep ? grant_q : 3'b000;
      note_d  = arb ? win_p : keep ? own_p : '0;
      busy_d  = state_d != IDLE;
   end
   assign out_note = note_q;
   assign grant    = grant_q;
   assign busy     = busy_q;
endmodule

// File: doc/note_arbiter.md
NOTE_ARBITER -- requirements
Module: note_arbiter

Interface
REQ-001 The block SHALL have parameter NOTE_W, default 19, meaning the width of a note half-period word, where 0 means Rest.
REQ-002 The block SHALL have parameter MIN_HOLD, default 1_500_000, meaning the minimum number of cycles an owner keeps the voice before it can be preempted (30 ms at 50 MHz).
REQ-003 The block SHALL have parameter GAP_CYC, default 50_000, meaning the number of silent cycles inserted between owners (1 ms).
REQ-004 The block SHALL have port CLOCK_50, input, 1 bit: the system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port req, input, 3 bits: request per source, where bit0 = sound effect (highest priority), bit1 = manual keys, bit2 = song player (lowest).
REQ-007 The block SHALL have ports period0, period1 and period2, each input, NOTE_W bits: the note word of each source, sampled every cycle.
REQ-008 The block SHALL have port out_note, output, NOTE_W bits, registered: the note word driven to the tone generator.
REQ-009 The block SHALL have port grant, output, 3 bits, registered, one-hot or zero: the current owner.
REQ-010 The block SHALL have port busy, output, 1 bit, registered: high in any state other than IDLE.

Function
REQ-011 The block SHALL implement the states IDLE, HOLD, OWN and GAP.
REQ-012 The winner SHALL be the lowest-index asserted req bit (fixed priority).
REQ-013 In IDLE, with any req asserted, the next cycle SHALL give:
- grant = winner one-hot
- out_note = period[winner]
- hold counter = MIN_HOLD-1
- state HOLD
The latency from req to grant SHALL be 1 cycle.
REQ-014 In HOLD and OWN, out_note SHALL track period[owner] each cycle with 1-cycle latency, so that period changes, including 0/Rest, pass through.
REQ-015 In HOLD, while req[owner] stays high, the hold counter SHALL decrement each cycle. When it reaches 0, the state SHALL go to OWN. Higher-priority requests SHALL be ignored during HOLD.
REQ-016 If req[owner] drops in HOLD or OWN, the next cycle SHALL give grant = 0, out_note = 0, gap counter = GAP_CYC-1, and state GAP.
REQ-017 In OWN, a higher-priority req SHALL cause the same transition to GAP (preemption). A lower-priority req SHALL be ignored.
REQ-018 In GAP:
- out_note SHALL be 0 and grant SHALL be 0.
- The gap counter SHALL decrement.
- At counter 0, the block SHALL re-arbitrate on req in that cycle: if any req is asserted, behave as REQ-013; otherwise go to IDLE.
REQ-019 When a higher-priority request and the owner's drop occur in the same cycle, the block SHALL take a single GAP entry.
REQ-020 A requester that releases and re-asserts during GAP SHALL be treated only by its level at the end of GAP.
REQ-021 If MIN_HOLD = 1, HOLD SHALL last exactly 1 cycle. If GAP_CYC = 1, GAP SHALL last exactly 1 cycle. Values of 0 are illegal.
REQ-022 Counters SHALL be sized with $clog2 of their parameter and SHALL never wrap below 0.

Reset
REQ-023 When resetn = 0 at a clock edge, the block SHALL set state IDLE, out_note = 0, grant = 0, busy = 0, and both counters = 0. This SHALL apply mid-note and mid-GAP alike, and reset SHALL take priority over all req.
REQ-024 On the first cycle after reset is released, the block SHALL arbitrate normally per REQ-013.

Structure
REQ-025 The note half-period constants (C4..B5), REST = 0 and NOTE_W SHALL live in the shared package note_pkg, which is used by the song player and this block.
REQ-026 The state encoding SHALL remain local to this module.
REQ-027 A single sub-module, hold_timer (loadable down-counter with a zero flag), SHALL be instantiated twice: once for HOLD and once for GAP.

Verification
All scenarios use MIN_HOLD = 8 and GAP_CYC = 4.
REQ-028 Reset: hold resetn = 0 with req = 3'b111 -> out_note = 0, grant = 0, busy = 0. On release -> grant = 3'b001 after 1 cycle.
REQ-029 Single source: req = 3'b100, period2 = E5 -> grant = 3'b100 and out_note = E5 after 1 cycle. Changing period2 to 0 -> out_note = 0 on the next cycle, grant unchanged.
REQ-030 Hold protection: song owns; assert req[0] at HOLD cycle 3 -> grant stays 3'b100 until HOLD ends. Then 4 GAP cycles (out_note = 0, grant = 0), then grant = 3'b001.
REQ-031 Release: owner drops req with no others -> 4 GAP cycles, then IDLE with busy = 0.
REQ-032 Lower-priority request during OWN: manual owns, song asserts req -> no change in grant.
REQ-033 Reset mid-GAP: assert resetn = 0 during GAP with req = 3'b010 -> IDLE. After release -> grant = 3'b010 after 1 cycle, with no residual GAP.
